// File: rtl/sys_bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter: FSM state encoding,
// handshake polarity constants and the width helper used for counters.
package sys_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Handshake polarities: request/ack are active-high, an idle wait line
  // (no ownership) reads as "keep waiting".
  localparam logic REQ_ON    = 1'b1;
  localparam logic ACK_ON    = 1'b1;
  localparam logic WAIT_IDLE = 1'b1;

  // Number of bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_select.sv
// Combinational round-robin picker over ports 1..NUM_REQ-1. Search starts
// at i_rr_ptr+1 and wraps from NUM_REQ-1 back to 1; port 0 never takes part.
module sys_bus_arbiter_rr_select
  import sys_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  int w_cand;
  logic w_hit;

  // Walk candidates in rotating order and latch the first requesting one.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    w_hit   = 1'b0;
    for (int k = 1; k < NUM_REQ; k++) begin
      w_cand = int'(i_rr_ptr) + k;
      w_cand = (w_cand > NUM_REQ - 1) ? (w_cand - (NUM_REQ - 1)) : w_cand;
      for (int j = 1; j < NUM_REQ; j++) begin
        w_hit   = !o_valid && (w_cand == j) && i_req[j];
        o_idx   = w_hit ? IDX_W'(j) : o_idx;
        o_valid = o_valid | w_hit;
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// System memory bus arbiter. Port 0 (VGA line fetcher) has priority, capped
// by a streak limit while other masters wait; ports 1..N-1 share the bus
// round-robin. A watchdog ends any grant held for TIMEOUT cycles, flags a
// sticky error and masks the offender until it drops its request.
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int PRIO_BURST_MAX = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ-1:0]        we_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        wait_out,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic                      mem_en,
  input  logic                      mem_wait,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int OWN_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam int STK_W = clog2(PRIO_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [STK_W-1:0] STREAK_CAP = STK_W'(PRIO_BURST_MAX);
  localparam logic [OWN_W-1:0] RR_RESET   = OWN_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [OWN_W-1:0]   r_owner, w_owner_nxt;
  logic [OWN_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_mask, w_mask_nxt;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [STK_W-1:0]   r_prio_streak, w_prio_streak_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_others;
  logic               w_cap;
  logic               w_prio_win;
  logic               w_rr_valid;
  logic [OWN_W-1:0]   w_rr_idx;
  logic [OWN_W-1:0]   w_winner;

  // A masked (timed-out) port is invisible to arbitration until it lets go.
  assign w_elig     = req & ~r_mask;
  assign w_others   = |w_elig[NUM_REQ-1:1];
  assign w_cap      = (r_prio_streak == STREAK_CAP) && w_others;
  assign w_prio_win = w_elig[0] && !w_cap;
  assign w_winner   = w_prio_win ? '0 : w_rr_idx;

  sys_bus_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_rr_select (
    .i_req    (w_elig[NUM_REQ-1:1]),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_rr_valid),
    .o_idx    (w_rr_idx)
  );

  // State register and all bookkeeping registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_rr_ptr      <= RR_RESET;
      r_ack         <= '0;
      r_mask        <= '0;
      r_hold_cnt    <= '0;
      r_prio_streak <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_ack         <= w_ack_nxt;
      r_mask        <= w_mask_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_prio_streak <= w_prio_streak_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, police the grant, one-cycle release.
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_ack_nxt         = r_ack;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_prio_streak_nxt = r_prio_streak;
    w_timeout_err_nxt = r_timeout_err;
    w_mask_nxt        = r_mask & req;
    case (r_state)
      ST_IDLE: begin
        w_ack_nxt = '0;
        if (w_prio_win || w_rr_valid) begin
          w_state_nxt    = ST_GRANT;
          w_owner_nxt    = w_winner;
          w_ack_nxt      = NUM_REQ'(ACK_ON) << w_winner;
          w_hold_cnt_nxt = '0;
          if (w_prio_win) begin
            if (!w_others) begin
              w_prio_streak_nxt = '0;
            end else if (r_prio_streak != STREAK_CAP) begin
              w_prio_streak_nxt = r_prio_streak + STK_W'(1);
            end else begin
              w_prio_streak_nxt = r_prio_streak;
            end
          end else begin
            w_prio_streak_nxt = '0;
            w_rr_ptr_nxt      = w_rr_idx;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        if (req[r_owner] != REQ_ON) begin
          // Normal release wins over a coincident timeout.
          w_state_nxt = ST_RELEASE;
          w_ack_nxt   = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt         = ST_RELEASE;
          w_ack_nxt           = '0;
          w_timeout_err_nxt   = 1'b1;
          w_mask_nxt[r_owner] = 1'b1;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_ack_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ack_nxt   = '0;
      end
    endcase
  end

  // Bus mux and wait routing: only the current owner sees memory's wait.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    wait_out = {NUM_REQ{WAIT_IDLE}};
    if (r_state == ST_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        mem_addr    = mem_addr | ((r_owner == OWN_W'(i)) ?
                      addr_in[i*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
        mem_we      = mem_we | ((r_owner == OWN_W'(i)) & we_in[i]);
        wait_out[i] = (r_owner == OWN_W'(i)) ? mem_wait : WAIT_IDLE;
      end
    end else begin
      mem_addr = '0;
      mem_we   = 1'b0;
      wait_out = {NUM_REQ{WAIT_IDLE}};
    end
  end

  assign ack         = r_ack;
  assign mem_en      = (r_state == ST_GRANT);
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_sys_bus_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int PBM = 2;
  localparam int TO  = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    we_in;
  logic [N-1:0]    ack;
  logic [N-1:0]    wait_out;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic            mem_en;
  logic            mem_wait;
  logic            busy;
  logic            timeout_err;

  logic [AW-1:0]   a_addr [N];

  int n_tests;
  int n_fail;

  // Reference model: who owns the bus (-1 = nobody), whether we are in the
  // post-grant dead cycle, cycles held, port-0 streak, last RR winner,
  // per-port lockout after a watchdog, sticky error.
  int m_owner;
  int m_held;
  int m_streak;
  int m_last_rr;
  bit m_rel;
  bit m_err;
  bit m_block [N];

  sys_bus_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .PRIO_BURST_MAX (PBM),
    .TIMEOUT        (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .addr_in     (addr_in),
    .we_in       (we_in),
    .ack         (ack),
    .wait_out    (wait_out),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_en      (mem_en),
    .mem_wait    (mem_wait),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eligible(input int i);
    return req[i] && !m_block[i];
  endfunction

  // Advance the model by one clock edge using the inputs now driven.
  task automatic model_step();
    bit others;
    int c;
    if (reset) begin
      m_owner = -1; m_rel = 1'b0; m_held = 0; m_streak = 0;
      m_last_rr = N - 1; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_block[i] = 1'b0;
      return;
    end
    if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner]) begin
        m_owner = -1; m_rel = 1'b1;
      end else if (m_held == TO) begin
        m_err = 1'b1; m_block[m_owner] = 1'b1; m_owner = -1; m_rel = 1'b1;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else begin
      others = 1'b0;
      for (int i = 1; i < N; i++) if (eligible(i)) others = 1'b1;
      if (eligible(0) && !(m_streak == PBM && others)) begin
        m_owner = 0; m_held = 0;
        m_streak = others ? ((m_streak < PBM) ? m_streak + 1 : PBM) : 0;
      end else if (others) begin
        for (int k = 1; k < N; k++) begin
          c = m_last_rr + k;
          if (c > N - 1) c = c - (N - 1);
          if (m_owner < 0 && eligible(c)) m_owner = c;
        end
        m_held = 0; m_streak = 0; m_last_rr = m_owner;
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) m_block[i] = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_wait;
    logic [AW-1:0] e_addr;
    logic          e_we;
    e_ack = '0; e_wait = '1; e_addr = '0; e_we = 1'b0;
    if (m_owner >= 0) begin
      e_ack[m_owner]  = 1'b1;
      e_wait[m_owner] = mem_wait;
      e_addr          = a_addr[m_owner];
      e_we            = we_in[m_owner];
    end
    check("ack", ack, e_ack);
    check("wait_out", wait_out, e_wait);
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, e_we);
    check("mem_en", mem_en, m_owner >= 0);
    check("busy", busy, (m_owner >= 0) || m_rel);
    check("timeout_err", timeout_err, m_err);
  endtask

  // One clock: drive, update model, let the edge happen, compare just after it.
  task automatic step();
    for (int i = 0; i < N; i++) addr_in[i*AW +: AW] = a_addr[i];
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic int ack_idx(input logic [N-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (a[i]) r = i;
    return r;
  endfunction

  initial begin
    int order[$];
    int exp_starv[6];
    int exp_rr[5];
    int hold_n;
    logic [N-1:0] prev_ack;

    exp_starv = '{0, 0, 1, 0, 0, 1};
    exp_rr    = '{1, 2, 3, 1, 2};
    n_tests = 0; n_fail = 0;
    reset = 1'b1; req = '0; we_in = '0; mem_wait = 1'b0; addr_in = '0;
    for (int i = 0; i < N; i++) a_addr[i] = 32'h0;
    step(); step();
    check("rst_ack", ack, 4'b0000);
    check("rst_wait", wait_out, 4'b1111);
    check("rst_en", mem_en, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    reset = 1'b0;
    step(); step(); step();

    // Single grant on port 0, request held for four cycles.
    a_addr[0] = 32'h0000_1050; we_in = 4'b0001; req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      check("sg_ack", ack, 4'b0001);
      check("sg_addr", mem_addr, 32'h0000_1050);
      check("sg_en", mem_en, 1'b1);
    end
    req = 4'b0000; we_in = 4'b0000;
    step(); check("sg_drop", ack, 4'b0000);
    step(); step();

    // Priority: port 0 first, port 2 two cycles after ack[0] falls.
    req = 4'b0101; step(); check("pr_first", ack, 4'b0001);
    req = 4'b0100; step(); check("pr_gap1", ack, 4'b0000);
    step(); check("pr_gap2", ack, 4'b0000);
    step(); check("pr_second", ack, 4'b0100);
    req = 4'b0000; step(); step(); step();

    // Starvation cap: port 0 re-requests at once, port 1 held.
    order.delete(); prev_ack = ack;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      req = {2'b00, !ack[1], !ack[0]};
      step();
      if (ack != 4'b0000 && prev_ack == 4'b0000) order.push_back(ack_idx(ack));
      prev_ack = ack;
    end
    check("starv_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      check("starv_order", (i < order.size()) ? order[i] : -1, exp_starv[i]);
    req = 4'b0000; step(); step(); step();

    // Round-robin from a fresh pointer.
    reset = 1'b1; step(); reset = 1'b0; step();
    order.delete(); prev_ack = ack;
    for (int cyc = 0; cyc < 60 && order.size() < 5; cyc++) begin
      req = {!ack[3], !ack[2], !ack[1], 1'b0};
      step();
      if (ack != 4'b0000 && prev_ack == 4'b0000) order.push_back(ack_idx(ack));
      prev_ack = ack;
    end
    check("rr_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < order.size()) ? order[i] : -1, exp_rr[i]);
    req = 4'b0000; step(); step(); step();

    // Watchdog: port 3 stuck high.
    req = 4'b1000; hold_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (ack[3]) hold_n++;
      else if (hold_n > 0) break;
    end
    check("wd_len", hold_n, TO);
    check("wd_err", timeout_err, 1'b1);
    req = 4'b1010; step(); check("wd_gap", ack, 4'b0000);
    step(); check("wd_p1", ack, 4'b0010);
    req = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step(); check("wd_masked", ack, 4'b0000);
    end
    req = 4'b0000; step(); check("wd_low", ack, 4'b0000);
    req = 4'b1000; step(); check("wd_regrant", ack, 4'b1000);
    req = 4'b0000; step(); step();

    // Wait routing, then reset in the middle of a grant.
    a_addr[1] = 32'hABCD_0004; req = 4'b0010; mem_wait = 1'b1;
    step();
    check("wr_ack", ack, 4'b0010);
    check("wr_wait_hi", wait_out, 4'b1111);
    mem_wait = 1'b0; step();
    check("wr_wait_lo", wait_out, 4'b1101);
    check("wr_addr", mem_addr, 32'hABCD_0004);
    check("wr_err_before", timeout_err, 1'b1);
    reset = 1'b1; step();
    check("wr_rst_ack", ack, 4'b0000);
    check("wr_rst_en", mem_en, 1'b0);
    check("wr_rst_err", timeout_err, 1'b0);
    reset = 1'b0; req = 4'b0000; step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        a_addr[i] = $urandom;
      end
      we_in    = N'($urandom);
      mem_wait = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
